// File: rtl/remote_cmd_if.sv
// Remote command interface: 8N1 UART receiver feeding a 3-byte packet assembler
// (cmd + 16-bit data with ready/clear handshake) plus a 1-byte response transmitter.
module remote_cmd_if #(
    parameter int BAUD_DIV = 2604,
    parameter int GAP_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        frm_err
);

    localparam int CNT_W     = $clog2(BAUD_DIV + 1);
    localparam int GAP_LIMIT = GAP_BITS * BAUD_DIV;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] WAIT_CMD = 2'd0;
    localparam logic [1:0] WAIT_HI  = 2'd1;
    localparam logic [1:0] WAIT_LO  = 2'd2;

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_XMIT = 1'b1;

    logic             rx_p0, rx_p1;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_tick, start_det, byte_vld_p0, stop_bad;

    logic [1:0]       pkt_state;
    logic [7:0]       stg_cmd, stg_hi;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_to, pkt_busy;

    logic [0:0]       tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [8:0]       tx_shift;

    // ---- stage p0/p1: RX synchroniser, idle-high preset ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= RX;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_tick     = (rx_cnt == CNT_ONE);
    assign start_det   = (rx_state == RX_IDLE) && !rx_p1;
    assign byte_vld_p0 = (rx_state == RX_STOP) && rx_tick && rx_p1;
    assign stop_bad    = (rx_state == RX_STOP) && rx_tick && !rx_p1;

    // ---- RX bit engine: half-bit delay to centre, then one sample per bit ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            frm_err  <= 1'b0;
        end else begin
            frm_err <= stop_bad;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_p1) begin
                        rx_cnt   <= HALF_BIT;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_p1) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_cnt   <= FULL_BIT;
                            rx_bit   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= FULL_BIT;
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                default: begin
                    if (rx_tick)
                        rx_state <= RX_IDLE;
                    else
                        rx_cnt <= rx_cnt - CNT_ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((rx_state == RX_DATA) && rx_tick)
            rx_shift <= {rx_p1, rx_shift[7:1]};
    end

    // ---- packet assembly and inter-byte gap timeout ----
    assign pkt_busy = (pkt_state != WAIT_CMD);
    assign gap_to   = (gap_cnt == GAP_W'(GAP_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gap_cnt <= '0;
        else if (!pkt_busy || start_det || gap_to)
            gap_cnt <= '0;
        else if (rx_state == RX_IDLE)
            gap_cnt <= gap_cnt + GAP_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_state <= WAIT_CMD;
            cmd       <= '0;
            data      <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            if (stop_bad || gap_to) begin
                pkt_state <= WAIT_CMD;
            end else if (byte_vld_p0) begin
                case (pkt_state)
                    WAIT_CMD: pkt_state <= WAIT_HI;
                    WAIT_HI:  pkt_state <= WAIT_LO;
                    WAIT_LO: begin
                        pkt_state <= WAIT_CMD;
                        cmd       <= stg_cmd;
                        data      <= {stg_hi, rx_shift};
                    end
                    default:  pkt_state <= WAIT_CMD;
                endcase
            end
            // completion wins over a simultaneous clear
            if (byte_vld_p0 && (pkt_state == WAIT_LO))
                cmd_rdy <= 1'b1;
            else if ((byte_vld_p0 && (pkt_state == WAIT_CMD)) || clr_cmd_rdy)
                cmd_rdy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_vld_p0 && (pkt_state == WAIT_CMD))
            stg_cmd <= rx_shift;
        if (byte_vld_p0 && (pkt_state == WAIT_HI))
            stg_hi <= rx_shift;
    end

    // ---- TX engine: start, 8 data LSB first, stop; resp_sent flags the final cycle ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= (tx_state == TX_XMIT) && (tx_bit == 4'd9) && (tx_cnt == CNT_ONE);
            case (tx_state)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_state <= TX_XMIT;
                        TX       <= 1'b0;
                        tx_cnt   <= TX_LAST;
                        tx_bit   <= '0;
                    end
                end
                default: begin
                    if (tx_cnt == '0) begin
                        if (tx_bit == 4'd9) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            TX     <= tx_shift[0];
                            tx_bit <= tx_bit + 4'd1;
                            tx_cnt <= TX_LAST;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((tx_state == TX_IDLE) && send_resp)
            tx_shift <= {1'b1, resp};
        else if ((tx_state == TX_XMIT) && (tx_cnt == '0))
            tx_shift <= {1'b1, tx_shift[8:1]};
    end

endmodule

// File: tb/tb_remote_cmd_if.sv
// Bench for remote_cmd_if: byte-level packet model with a per-cycle output
// scoreboard, plus directed checks on timing, framing errors, timeout and TX.
module tb_remote_cmd_if;

    localparam int BD  = 16;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_line = 1'b1;
    logic        tx_line;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;
    logic        frm_err;

    int total = 0;
    int bad   = 0;

    // byte-level model state
    int          pkt_st = 0;
    logic [7:0]  m_cmd, m_hi;
    logic [23:0] exp_q[$];
    logic [23:0] cur_out = 24'h0;
    int          exp_frm = 0;
    int          seen_frm = 0;

    remote_cmd_if #(.BAUD_DIV(BD), .GAP_BITS(GAP)) dut (
        .clk(clk), .rst(rst), .RX(rx_line), .TX(tx_line),
        .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            pkt_st = 0;
            exp_frm++;
        end else if (pkt_st == 0) begin
            m_cmd  = b;
            pkt_st = 1;
        end else if (pkt_st == 1) begin
            m_hi   = b;
            pkt_st = 2;
        end else begin
            exp_q.push_back({m_cmd, m_hi, b});
            pkt_st = 0;
        end
    endfunction

    // idle periods well beyond GAP*BD clocks abandon a partial packet
    task automatic idle(input int n);
        if (n >= GAP * BD - 4)
            pkt_st = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        logic [9:0] fr;
        model_byte(b, ok);
        fr = {ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = fr[i];
            repeat (BD) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx"},   {31'd0, tx_line},   32'd1);
        check({tag, "_cmd"},  {24'd0, cmd},       32'd0);
        check({tag, "_data"}, {16'd0, data},      32'd0);
        check({tag, "_rdy"},  {31'd0, cmd_rdy},   32'd0);
        check({tag, "_rs"},   {31'd0, resp_sent}, 32'd0);
        check({tag, "_fe"},   {31'd0, frm_err},   32'd0);
    endtask

    // scoreboard: every rising cmd_rdy must deliver the next modelled packet,
    // and cmd/data must otherwise hold the last delivered packet
    initial begin
        logic prev_rdy, prev_fe;
        logic [23:0] e;
        prev_rdy = 1'b0;
        prev_fe  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_rdy = cmd_rdy;
                prev_fe  = frm_err;
            end else begin
                if (cmd_rdy && !prev_rdy) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pkt: got %0h expected none", {cmd, data});
                    end else begin
                        e = exp_q.pop_front();
                        check("pkt", {8'd0, cmd, data}, {8'd0, e});
                        cur_out = e;
                    end
                end else begin
                    check("hold", {8'd0, cmd, data}, {8'd0, cur_out});
                end
                if (frm_err) begin
                    seen_frm++;
                    check("frm_width", {31'd0, prev_fe}, 32'd0);
                end
                prev_rdy = cmd_rdy;
                prev_fe  = frm_err;
            end
        end
    end

    initial begin
        logic [9:0] frame;
        int rs_n, rs_c, tx_bad;

        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b0;
        idle(5);

        // basic packet and clear handshake
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("t1_rdy",  {31'd0, cmd_rdy}, 32'd1);
        check("t1_cmd",  {24'd0, cmd},     32'h02);
        check("t1_data", {16'd0, data},    32'h1234);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("t1_clr",   {31'd0, cmd_rdy}, 32'd0);
        check("t1_hold",  {8'd0, cmd, data}, 32'h021234);

        // next packet's first byte clears a still-pending cmd_rdy
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h07, 1'b1);
        check("t2_rdy_a", {31'd0, cmd_rdy}, 32'd1);
        send_byte(8'h05, 1'b1);
        check("t2_drop",  {31'd0, cmd_rdy}, 32'd0);
        check("t2_keep",  {8'd0, cmd, data}, 32'h010007);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("t2_rdy_b", {31'd0, cmd_rdy}, 32'd1);
        check("t2_out",   {8'd0, cmd, data}, 32'h0501FF);

        // gap timeout drops a partial packet
        send_byte(8'h03, 1'b1);
        send_byte(8'hAA, 1'b1);
        idle(70);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        check("t3_out", {8'd0, cmd, data}, 32'h040010);
        check("t3_rdy", {31'd0, cmd_rdy}, 32'd1);

        // framing error in the middle byte
        send_byte(8'h06, 1'b1);
        send_byte(8'h07, 1'b0);
        check("t4_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("t4_fe",  seen_frm, 32'd1);
        idle(24);
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("t4_out", {8'd0, cmd, data}, 32'h080000);
        check("t4_rdy2", {31'd0, cmd_rdy}, 32'd1);

        // response transmit with ignored mid-frame and final-cycle requests
        frame = {1'b1, 8'hA5, 1'b0};
        rs_n = 0;
        rs_c = -1;
        tx_bad = 0;
        resp = 8'hA5;
        send_resp = 1'b1;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
        resp = 8'h00;
        for (int c = 0; c < 176; c++) begin
            if ((c < 160) && (c % 16 == 8))
                check($sformatf("tx_bit%0d", c / 16), {31'd0, tx_line}, {31'd0, frame[c / 16]});
            if (resp_sent) begin
                rs_n++;
                rs_c = c;
            end
            if ((c >= 160) && (tx_line !== 1'b1))
                tx_bad++;
            send_resp = (c == 50) || (c == 159);
            @(posedge clk);
            #1;
        end
        send_resp = 1'b0;
        check("tx_rs_count", rs_n, 32'd1);
        check("tx_rs_cycle", rs_c, 32'd159);
        check("tx_idle_after", tx_bad, 32'd0);
        @(negedge clk);

        // RX glitch, then reset mid-packet
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        idle(30);
        check("t6_glitch_fe", seen_frm, 32'd1);
        send_byte(8'h09, 1'b1);
        send_byte(8'h11, 1'b1);
        rx_line = 1'b0;
        repeat (BD) @(negedge clk);
        rx_line = 1'b1;
        repeat (BD) @(negedge clk);
        rx_line = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        rx_line = 1'b1;
        exp_q.delete();
        pkt_st = 0;
        cur_out = 24'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst1");
        idle(5);
        send_byte(8'h0A, 1'b1);
        send_byte(8'hBC, 1'b1);
        send_byte(8'hDE, 1'b1);
        check("t6_out", {8'd0, cmd, data}, 32'h0ABCDE);
        check("t6_rdy", {31'd0, cmd_rdy}, 32'd1);

        idle(10);
        check("frm_total", seen_frm, exp_frm);
        check("pkts_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
